// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of COUNT unsigned products from the
// upstream multiplier. Each completed group is presented as a sum with a
// sticky overflow flag on a valid/ready output handshake.
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH-1:0]       product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     sum,
  output logic                     overflow,
  output logic [$clog2(COUNT)-1:0] beats
);

  localparam int BW = $clog2(COUNT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(COUNT-1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [BW-1:0]          beats_q, beats_d;
  logic                   sticky_q, sticky_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     acc_next;

  // Zero-extend the product and form the accumulator sum with its carry bit.
  always_comb begin
    prod_ext                = '0;
    prod_ext[2*WIDTH-1:0]   = product;
    acc_next                = {1'b0, acc_q} + prod_ext;
  end

  // Next-state, accumulation and handshake logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    sticky_d    = sticky_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready    = (state_q == ACCUM) && !clear;

    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d    = '0;
          beats_d  = '0;
          sticky_d = 1'b0;
        end else if (in_valid) begin
          if (beats_q == LAST_BEAT) begin
            sum_d       = acc_next[ACC_WIDTH-1:0];
            ovf_d       = sticky_q | acc_next[ACC_WIDTH];
            out_valid_d = 1'b1;
            state_d     = DONE;
            acc_d       = '0;
            beats_d     = '0;
            sticky_d    = 1'b0;
          end else begin
            acc_d    = acc_next[ACC_WIDTH-1:0];
            sticky_d = sticky_q | acc_next[ACC_WIDTH];
            beats_d  = beats_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      beats_q     <= '0;
      sticky_q    <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      sticky_q    <= sticky_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign beats     = beats_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives two accumulators (17- and 18-bit sums) with
// identical stimulus and compares them against a group-level reference model.
module tb_product_accumulator;

  localparam int W = 8;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic [15:0] product;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [16:0] sum_a;
  logic [1:0]  beats_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [17:0] sum_b;
  logic [1:0]  beats_b;

  int checks = 0;
  int errors = 0;

  // Reference model: products of the open group, and the pending group total.
  bit          pending;
  longint      total_exp;
  int unsigned grp[$];

  always #5 clk = ~clk;

  product_accumulator #(.WIDTH(W), .COUNT(C), .ACC_WIDTH(17)) u_dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_a), .product(product), .out_valid(out_valid_a),
    .out_ready(out_ready), .sum(sum_a), .overflow(ovf_a), .beats(beats_a)
  );

  product_accumulator #(.WIDTH(W), .COUNT(C), .ACC_WIDTH(18)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_b), .product(product), .out_valid(out_valid_b),
    .out_ready(out_ready), .sum(sum_b), .overflow(ovf_b), .beats(beats_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("in_ready_a", 64'(in_ready_a), 64'(!pending && !clear));
    check("in_ready_b", 64'(in_ready_b), 64'(!pending && !clear));
    check("out_valid_a", 64'(out_valid_a), 64'(pending));
    check("out_valid_b", 64'(out_valid_b), 64'(pending));
    check("beats_a", 64'(beats_a), 64'(grp.size()));
    check("beats_b", 64'(beats_b), 64'(grp.size()));
    if (pending) begin
      check("sum_a", 64'(sum_a), 64'(total_exp % (64'd1 << 17)));
      check("ovf_a", 64'(ovf_a), 64'(total_exp >= (64'd1 << 17)));
      check("sum_b", 64'(sum_b), 64'(total_exp % (64'd1 << 18)));
      check("ovf_b", 64'(ovf_b), 64'(total_exp >= (64'd1 << 18)));
    end
  endtask

  task automatic check_reset_values();
    check("rst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_sum_a", 64'(sum_a), 64'd0);
    check("rst_sum_b", 64'(sum_b), 64'd0);
    check("rst_ovf_a", 64'(ovf_a), 64'd0);
    check("rst_ovf_b", 64'(ovf_b), 64'd0);
    check("rst_beats_a", 64'(beats_a), 64'd0);
    check("rst_beats_b", 64'(beats_b), 64'd0);
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // by what the rising edge will see.
  task automatic cycle(input bit v, input int unsigned p, input bit clr, input bit ordy);
    @(negedge clk);
    in_valid  = v;
    product   = p[15:0];
    clear     = clr;
    out_ready = ordy;
    #1;
    check_outputs();
    if (pending) begin
      if (ordy) pending = 1'b0;
    end else if (clr) begin
      grp.delete();
    end else if (v) begin
      grp.push_back(p);
      if (grp.size() == C) begin
        total_exp = 0;
        foreach (grp[i]) total_exp += longint'(grp[i]);
        pending = 1'b1;
        grp.delete();
      end
    end
  endtask

  task automatic group4(input int unsigned p0, p1, p2, p3, input bit ordy);
    cycle(1'b1, p0, 1'b0, ordy);
    cycle(1'b1, p1, 1'b0, ordy);
    cycle(1'b1, p2, 1'b0, ordy);
    cycle(1'b1, p3, 1'b0, ordy);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_values();
    pending = 1'b0;
    grp.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_rel_a", 64'(in_ready_a), 64'd1);
    check("in_ready_rel_b", 64'(in_ready_b), 64'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; product = '0;
    pending = 1'b0; total_exp = 0;
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // Basic group, then wrap at 17 bits but not at 18, then a small group.
    group4(10, 20, 30, 40, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    group4(65025, 65025, 65025, 65025, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    group4(1, 1, 1, 1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Gaps on input, then 5 cycles of output backpressure with input pending.
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 4, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 77, 1'b0, 1'b0);
    cycle(1'b1, 77, 1'b0, 1'b1);
    group4(77, 1, 1, 1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Clear aborts a partial group; clear in DONE is ignored.
    cycle(1'b1, 7, 1'b0, 1'b1);
    cycle(1'b1, 9, 1'b0, 1'b1);
    cycle(1'b1, 100, 1'b1, 1'b1);
    group4(1, 2, 3, 4, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    group4(1, 1, 1, 1, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b1, 9, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-group and in DONE.
    cycle(1'b1, 11, 1'b0, 1'b1);
    cycle(1'b1, 12, 1'b0, 1'b1);
    do_reset();
    group4(5, 5, 5, 5, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    do_reset();
    group4(5, 5, 5, 5, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Randomized traffic, biased toward large products to exercise wrap.
    for (int i = 0; i < 600; i++) begin
      int unsigned p;
      p = ($urandom_range(0, 3) == 0) ? 32'd65025 - $urandom_range(0, 50) : $urandom_range(0, 65535);
      cycle($urandom_range(0, 9) < 7, p, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
